acc_unit: RTL and testbench

Registered accumulator that sits directly downstream of the `add_sub` datapath: it holds the running operand A, feeds A/B/sel into an `add_sub` instance, and captures {Cout,S} back into the accumulator. Operations arrive over a valid/ready input handshake. Results and flags leave over a valid/ready output handshake. It turns the combinational adder/subtractor into a sequenced, flow-controlled arithmetic stage.

---
 rtl/acc_pkg.sv | 20 ++
 rtl/add_sub.sv | 18 +
 rtl/acc_unit.sv | 108 ++++++++++
 tb/tb_acc_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accumulator stage: op codes, FSM states and
// default datapath width.
package acc_pkg;

  localparam int ACC_N = 4;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/add_sub.sv
// Combinational N-bit adder/subtractor.
// Ports: A, B operands; sel 0=add 1=sub; S result; Cout carry (add) or borrow (sub).
module add_sub #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sel,
  output logic [N-1:0] S,
  output logic         Cout
);

  always_comb begin
    if (sel) {Cout, S} = {1'b0, A} - {1'b0, B};
    else     {Cout, S} = {1'b0, A} + {1'b0, B};
  end

endmodule

// File: rtl/acc_unit.sv
// Flow-controlled accumulator around add_sub: in/out valid/ready, flags.
// Ports: clk, rst, in_valid/in_ready, op, B, out_valid/out_ready,
// acc, carry, zero, ovf. Optional ACC_SAT_EN: unsigned saturation.
module acc_unit
  import acc_pkg::*;
#(
  parameter int N = ACC_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] acc,
  output logic         carry,
  output logic         zero,
  output logic         ovf
);

  state_e       state_q;
  state_e       state_d;
  op_e          op_q;
  logic [N-1:0] b_q;
  logic [N-1:0] s;
  logic         cout;
  logic [N-1:0] acc_d;
  logic         carry_d;
  logic         ovf_d;
  logic         take;

  add_sub #(.N(N)) u_add_sub (
    .A    (acc),
    .B    (b_q),
    .sel  (op_q == OP_SUB),
    .S    (s),
    .Cout (cout)
  );

  always_comb begin
    in_ready = !rst && ((state_q == S_IDLE) ||
                        (state_q == S_DONE && out_ready));
    take      = in_valid && in_ready;
    out_valid = (state_q == S_DONE);
    state_d   = state_q;
    unique case (state_q)
      S_IDLE:  if (take) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE: begin
        if (out_ready) state_d = in_valid ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        acc_d   = s;
        carry_d = cout;
        ovf_d   = (acc[N-1] == b_q[N-1]) && (s[N-1] != acc[N-1]);
      end
      OP_SUB: begin
        acc_d   = s;
        carry_d = cout;
        ovf_d   = (acc[N-1] != b_q[N-1]) && (s[N-1] != acc[N-1]);
      end
      OP_LOAD:  acc_d = b_q;
      OP_CLEAR: acc_d = '0;
      default:  acc_d = '0;
    endcase
`ifdef ACC_SAT_EN
    // Saturate toward the rail the unsigned result ran past.
    if (cout && op_q == OP_ADD) acc_d = '1;
    if (cout && op_q == OP_SUB) acc_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      b_q     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_q <= op_e'(op);
        b_q  <= B;
      end
      if (state_q == S_EXEC) begin
        acc   <= acc_d;
        carry <= carry_d;
        ovf   <= ovf_d;
        zero  <= (acc_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: directed cases plus random ops
// against an integer-arithmetic reference model.
module tb_acc_unit;

  localparam int N = 4;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] acc;
  logic         carry;
  logic         zero;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;
  int m_acc = 0;
  int m_carry = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  acc_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  function automatic void model(input int o, input int b);
    int r;
    int sr;
    case (o)
      0: begin
        r       = m_acc + b;
        sr      = sx(m_acc) + sx(b);
        m_carry = (r >= M) ? 1 : 0;
        m_ovf   = (sr > M / 2 - 1 || sr < -M / 2) ? 1 : 0;
        m_acc   = r % M;
`ifdef ACC_SAT_EN
        if (m_carry == 1) m_acc = M - 1;
`endif
      end
      1: begin
        r       = m_acc - b;
        sr      = sx(m_acc) - sx(b);
        m_carry = (r < 0) ? 1 : 0;
        m_ovf   = (sr > M / 2 - 1 || sr < -M / 2) ? 1 : 0;
        m_acc   = (r + M) % M;
`ifdef ACC_SAT_EN
        if (m_carry == 1) m_acc = 0;
`endif
      end
      2: begin
        m_acc = b; m_carry = 0; m_ovf = 0;
      end
      default: begin
        m_acc = 0; m_carry = 0; m_ovf = 0;
      end
    endcase
  endfunction

  task automatic chk_res(input string tag);
    chk({tag, "_acc"}, int'(acc), m_acc);
    chk({tag, "_carry"}, int'(carry), m_carry);
    chk({tag, "_ovf"}, int'(ovf), m_ovf);
    chk({tag, "_zero"}, int'(zero), (m_acc == 0) ? 1 : 0);
  endtask

  // Present one op from IDLE, check latency, leave at the negedge
  // where out_valid is first high.
  task automatic send(input int o, input int b);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    op = 2'(o);
    B = N'(b);
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(o, b);
    @(negedge clk);
    chk("lat_exec", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_done", int'(out_valid), 1);
  endtask

  // Stall for hold cycles checking stability, then accept.
  task automatic accept(input int hold, input bit verbose);
    int a0;
    int f0;
    a0 = int'(acc);
    f0 = int'({carry, zero, ovf});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (verbose) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_acc", int'(acc), a0);
        chk("stall_flags", int'({carry, zero, ovf}), f0);
        chk("stall_ready", int'(in_ready), 0);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_carry", int'(carry), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(in_ready), 1);

    send(2, 5);  chk_res("load5");  accept(0, 0);
    send(0, 12); chk_res("add12");  accept(0, 0);
    send(2, 3);  chk_res("load3");  accept(0, 0);
    send(1, 5);  chk_res("sub5");   accept(0, 0);
    send(2, 7);  chk_res("load7");  accept(0, 0);
    send(0, 1);  chk_res("add_ovf"); accept(0, 0);

    // Back-pressure with a CLEAR waiting, then back-to-back transfer.
    send(2, 6);  chk_res("load6");
    @(posedge clk); #1;
    in_valid = 1'b1; op = 2'(3); B = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_acc", int'(acc), 6);
      chk("bp_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    model(3, 0);
    @(negedge clk);
    chk("b2b_exec", int'(out_valid), 0);
    @(negedge clk);
    chk("b2b_done", int'(out_valid), 1);
    chk_res("clear");
    accept(0, 0);

    // Reset during EXEC abandons the ADD.
    send(2, 9); chk_res("load9"); accept(0, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; op = 2'(0); B = 4'h3;
    @(negedge clk);
    chk("rx_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rx_ready_low", int'(in_ready), 0);
    @(negedge clk);
    chk("rx_acc", int'(acc), 0);
    chk("rx_zero", int'(zero), 1);
    chk("rx_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = 0; m_carry = 0; m_ovf = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rx_no_result", int'(out_valid), 0);
      chk("rx_idle_ready", int'(in_ready), 1);
    end

    // Random sequences with random back-pressure.
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 6; k++) begin
        int o;
        int b;
        o = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, M - 1));
        send(o, b);
        chk_res("rand");
        accept(int'($urandom_range(0, 3)), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
